wb_regfile: RTL and testbench



---
 rtl/mips_pkg.sv | 18 +
 rtl/wb_regfile_if.sv | 45 ++++
 rtl/wb_regfile_regfile_2r1w.sv | 42 ++++
 rtl/wb_regfile.sv | 89 ++++++++
 tb/tb_wb_regfile.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// mips_pkg
// Shared types and constants for the writeback / register-file slice.
//   REG_ADDR_W : GPR address width (5 -> 32 architectural registers)
//   DATA_W     : default datapath width
//   REG_ZERO   : address of the hardwired-zero register
//   reg_addr_t : GPR address type
//   word_t     : datapath word type
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     word_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_regfile_if.sv
// wb_regfile_if
// Bus between the MEM/WB pipeline register, the decode read ports, the
// forwarding unit and wb_regfile.
//   master : pipeline side; drives the WB bundle and read addresses,
//            receives read data, the commit export and the retire count
//   slave  : wb_regfile side
// Parameters: DATA_W (word width), CNT_W (retired-instruction counter width)
interface wb_regfile_if
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
);

  logic              instr_retired_i;
  logic              reg_wr_i;
  logic              mem_to_reg_i;
  reg_addr_t         rd_i;
  logic [DATA_W-1:0] res_alu_i;
  logic [DATA_W-1:0] read_data_i;
  reg_addr_t         rs_addr_i;
  reg_addr_t         rt_addr_i;

  logic [DATA_W-1:0] rs_data_o;
  logic [DATA_W-1:0] rt_data_o;
  logic              wb_wr_en_o;
  reg_addr_t         wb_rd_o;
  logic [DATA_W-1:0] wb_data_o;
  logic [CNT_W-1:0]  retired_cnt_o;

  modport master (
    output instr_retired_i, reg_wr_i, mem_to_reg_i, rd_i,
           res_alu_i, read_data_i, rs_addr_i, rt_addr_i,
    input  rs_data_o, rt_data_o, wb_wr_en_o, wb_rd_o, wb_data_o,
           retired_cnt_o
  );

  modport slave (
    input  instr_retired_i, reg_wr_i, mem_to_reg_i, rd_i,
           res_alu_i, read_data_i, rs_addr_i, rt_addr_i,
    output rs_data_o, rt_data_o, wb_wr_en_o, wb_rd_o, wb_data_o,
           retired_cnt_o
  );

endinterface

// File: rtl/wb_regfile_regfile_2r1w.sv
// regfile_2r1w
// Raw storage array: NUM_REGS x DATA_W flops, one synchronous write port,
// two combinational read ports. No zero-register masking or bypass here;
// the wrapper owns those so this array stays a plain storage block.
// Ports:
//   clk, reset_n       : clock, async active-low clear of every entry
//   we_i, wa_i, wd_i   : write enable / address / data
//   ra_a_i, rd_a_o     : read port A address / data
//   ra_b_i, rd_b_o     : read port B address / data
module regfile_2r1w
  import mips_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we_i,
  input  reg_addr_t         wa_i,
  input  logic [DATA_W-1:0] wd_i,
  input  reg_addr_t         ra_a_i,
  output logic [DATA_W-1:0] rd_a_o,
  input  reg_addr_t         ra_b_i,
  output logic [DATA_W-1:0] rd_b_o
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we_i) begin
      regs[wa_i] <= wd_i;
    end
  end

  assign rd_a_o = regs[ra_a_i];
  assign rd_b_o = regs[ra_b_i];

endmodule

// File: rtl/wb_regfile.sv
// wb_regfile
// Writeback stage consumer: selects ALU result vs. load data, commits it to
// the 32x32 GPR file, serves the decode read ports (rs, rt) with same-cycle
// write bypass, and exports the committed write to the forwarding unit.
// Ports:
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : wb_regfile_if.slave (WB bundle in, read ports, commit export,
//             retired-instruction count)
// Optional feature macro: WB_RETIRE_CNT_EN
//   defined     -> CNT_W-bit wrapping count of retired instructions
//   not defined -> no counter flops, retired_cnt_o tied to 0
module wb_regfile #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  wb_regfile_if.slave  bus
);

  import mips_pkg::*;

  logic [DATA_W-1:0] wb_data;
  logic              wb_wr_en;
  logic [DATA_W-1:0] raw_rs;
  logic [DATA_W-1:0] raw_rt;

  assign wb_data  = bus.mem_to_reg_i ? bus.read_data_i : bus.res_alu_i;
  // Bubbles and rd=0 never commit, so downstream forwarding never sees them.
  assign wb_wr_en = bus.instr_retired_i & bus.reg_wr_i & (bus.rd_i != REG_ZERO);

  assign bus.wb_wr_en_o = wb_wr_en;
  assign bus.wb_rd_o    = bus.rd_i;
  assign bus.wb_data_o  = wb_data;

  regfile_2r1w #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_array (
    .clk     (clk),
    .reset_n (reset_n),
    .we_i    (wb_wr_en),
    .wa_i    (bus.rd_i),
    .wd_i    (wb_data),
    .ra_a_i  (bus.rs_addr_i),
    .rd_a_o  (raw_rs),
    .ra_b_i  (bus.rt_addr_i),
    .rd_b_o  (raw_rt)
  );

  // Zero check comes first so r0 stays 0 even if something tries to bypass it.
  always_comb begin
    bus.rs_data_o = raw_rs;
    if (bus.rs_addr_i == REG_ZERO) begin
      bus.rs_data_o = '0;
    end else if (wb_wr_en && (bus.rs_addr_i == bus.rd_i)) begin
      bus.rs_data_o = wb_data;
    end
  end

  always_comb begin
    bus.rt_data_o = raw_rt;
    if (bus.rt_addr_i == REG_ZERO) begin
      bus.rt_data_o = '0;
    end else if (wb_wr_en && (bus.rt_addr_i == bus.rd_i)) begin
      bus.rt_data_o = wb_data;
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] retired_cnt_q;

  // Counts every retired slot, whether or not it writes a GPR.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      retired_cnt_q <= '0;
    end else if (bus.instr_retired_i) begin
      retired_cnt_q <= retired_cnt_q + 1'b1;
    end
  end

  assign bus.retired_cnt_o = retired_cnt_q;
`else
  assign bus.retired_cnt_o = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

  import mips_pkg::*;

  localparam int TB_DW  = 32;
  localparam int TB_CW  = 4;

  localparam int S_RS   = 0;
  localparam int S_RT   = 1;
  localparam int S_WEN  = 2;
  localparam int S_WDAT = 3;
  localparam int S_CNT  = 4;
  localparam int S_WRD  = 5;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] exp;
    string       name;
  } chk_t;

  logic clk;
  logic reset_n;
  int   cyc;
  int   checks;
  int   errors;
  int   cnt_model;
  chk_t sb [$];
  chk_t cur;
  logic [31:0] act;

  wb_regfile_if #(.DATA_W(TB_DW), .CNT_W(TB_CW)) bus ();

  wb_regfile #(
    .DATA_W   (TB_DW),
    .NUM_REGS (32),
    .CNT_W    (TB_CW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: the DUT output is combinational, so it is presented every cycle;
  // compare everything scheduled for the current cycle at the falling edge.
  always @(negedge clk) begin
    while (sb.size() != 0 && sb[0].cyc <= cyc) begin
      cur = sb.pop_front();
      case (cur.sel)
        S_RS:    act = bus.rs_data_o;
        S_RT:    act = bus.rt_data_o;
        S_WEN:   act = {31'd0, bus.wb_wr_en_o};
        S_WDAT:  act = bus.wb_data_o;
        S_CNT:   act = {28'd0, bus.retired_cnt_o};
        S_WRD:   act = {27'd0, bus.wb_rd_o};
        default: act = 32'hxxxx_xxxx;
      endcase
      checks++;
      if (cur.cyc != cyc || act !== cur.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h (cycle %0d, scheduled %0d)",
                 cur.name, act, cur.exp, cyc, cur.cyc);
      end
    end
  end

  task automatic expect_val(input int sel, input logic [31:0] exp, input string name);
    chk_t e;
    e.cyc  = cyc;
    e.sel  = sel;
    e.exp  = exp;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic drive(input logic ret, input logic wr, input logic m2r,
                       input reg_addr_t rd, input logic [31:0] alu,
                       input logic [31:0] ld, input reg_addr_t rs,
                       input reg_addr_t rt);
    bus.instr_retired_i = ret;
    bus.reg_wr_i        = wr;
    bus.mem_to_reg_i    = m2r;
    bus.rd_i            = rd;
    bus.res_alu_i       = alu;
    bus.read_data_i     = ld;
    bus.rs_addr_i       = rs;
    bus.rt_addr_i       = rt;
  endtask

  task automatic step();
    @(posedge clk);
    if (reset_n && bus.instr_retired_i) cnt_model++;
    #1;
    cyc++;
  endtask

  task automatic write_reg(input reg_addr_t rd, input logic [31:0] d);
    drive(1'b1, 1'b1, 1'b0, rd, d, 32'h0, 5'd0, 5'd0);
    step();
  endtask

  function automatic logic [31:0] cnt_exp(input int n);
`ifdef WB_RETIRE_CNT_EN
    return 32'(n % 16);
`else
    return 32'(n * 0);
`endif
  endfunction

  initial begin
    cyc       = 0;
    checks    = 0;
    errors    = 0;
    cnt_model = 0;
    reset_n   = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd0);
    step();

    expect_val(S_RS,  32'h0, "por_rs_r5");
    expect_val(S_CNT, 32'h0, "por_cnt");
    expect_val(S_WEN, 32'h0, "por_wen");
    @(negedge clk); #1;
    reset_n = 1'b1;
    step();

    // ALU result selected
    drive(1'b1, 1'b1, 1'b0, 5'd3, 32'h11, 32'h22, 5'd3, 5'd0);
    expect_val(S_WDAT, 32'h11, "mux_alu_wbdata");
    expect_val(S_WEN,  32'h1,  "mux_alu_wen");
    expect_val(S_WRD,  32'h3,  "mux_alu_wbrd");
    expect_val(S_RS,   32'h11, "mux_alu_bypass_rs");
    expect_val(S_RT,   32'h0,  "rt_r0_zero");
    step();
    drive(1'b0, 1'b0, 1'b0, 5'd3, 32'h0, 32'h0, 5'd3, 5'd3);
    expect_val(S_RS, 32'h11, "mux_alu_r3_rs");
    expect_val(S_RT, 32'h11, "mux_alu_r3_rt");
    step();

    // Load data selected
    drive(1'b1, 1'b1, 1'b1, 5'd3, 32'h11, 32'h22, 5'd0, 5'd0);
    expect_val(S_WDAT, 32'h22, "mux_ld_wbdata");
    step();
    drive(1'b0, 1'b0, 1'b0, 5'd3, 32'h0, 32'h0, 5'd3, 5'd0);
    expect_val(S_RS, 32'h22, "mux_ld_r3");
    step();

    // Dual bypass rs=rt=rd
    drive(1'b1, 1'b1, 1'b0, 5'd7, 32'hA5A5A5A5, 32'h0, 5'd7, 5'd7);
    expect_val(S_RS, 32'hA5A5A5A5, "bypass_rs_pre");
    expect_val(S_RT, 32'hA5A5A5A5, "bypass_rt_pre");
    step();
    drive(1'b0, 1'b0, 1'b0, 5'd7, 32'h0, 32'h0, 5'd7, 5'd7);
    expect_val(S_RS, 32'hA5A5A5A5, "bypass_rs_post");
    expect_val(S_RT, 32'hA5A5A5A5, "bypass_rt_post");
    step();

    write_reg(5'd9, 32'h55);
    write_reg(5'd5, 32'hDEADBEEF);

    // Zero register write is dropped
    drive(1'b1, 1'b1, 1'b0, 5'd0, 32'hFFFFFFFF, 32'h0, 5'd0, 5'd7);
    expect_val(S_WEN, 32'h0,        "zero_wen");
    expect_val(S_RS,  32'h0,        "zero_rs_pre");
    expect_val(S_RT,  32'hA5A5A5A5, "zero_rt_r7_pre");
    step();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd3);
    expect_val(S_RS, 32'h0,  "zero_rs_post");
    expect_val(S_RT, 32'h22, "zero_r3_kept");
    step();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd9, 5'd7);
    expect_val(S_RS, 32'h55,       "zero_r9_kept");
    expect_val(S_RT, 32'hA5A5A5A5, "zero_r7_kept");
    expect_val(S_CNT, cnt_exp(cnt_model), "cnt_before_bubble");
    step();

    // Bubble never writes or counts
    drive(1'b0, 1'b1, 1'b0, 5'd9, 32'h1234, 32'h0, 5'd9, 5'd0);
    expect_val(S_WEN, 32'h0,  "bubble_wen");
    expect_val(S_RS,  32'h55, "bubble_rs_pre");
    step();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd9, 5'd5);
    expect_val(S_RS,  32'h55,       "bubble_r9_kept");
    expect_val(S_RT,  32'hDEADBEEF, "r5_before_reset");
    expect_val(S_CNT, cnt_exp(cnt_model), "bubble_cnt_same");
    step();

    // Async reset mid-cycle, with a write in flight across the reset edge
    drive(1'b1, 1'b1, 1'b0, 5'd11, 32'h77, 32'h0, 5'd5, 5'd0);
    #2;
    reset_n = 1'b0;
    cnt_model = 0;
    expect_val(S_RS,  32'h0, "areset_r5");
    expect_val(S_CNT, 32'h0, "areset_cnt");
    step();
    @(negedge clk); #1;
    reset_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd11, 5'd5);
    step();
    expect_val(S_RS,  32'h0, "reset_drop_r11");
    expect_val(S_RT,  32'h0, "reset_r5_cleared");
    expect_val(S_CNT, 32'h0, "reset_cnt_zero");
    step();

    // 10 retirements, mixed reg_wr; last write (i=9) leaves r12=9
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'(i % 2), 1'b0, 5'd12, 32'(i), 32'h0, 5'd0, 5'd0);
      step();
    end
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd12, 5'd0);
`ifdef WB_RETIRE_CNT_EN
    expect_val(S_CNT, 32'd10, "cnt_10");
`else
    expect_val(S_CNT, 32'd0, "cnt_off_10");
`endif
    expect_val(S_RS, 32'd9, "cnt_loop_r12");
    step();

    // 7 more (including rd=0 writes) -> 17 retirements wraps a 4-bit count to 1
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b1, 1'b0, 5'd0, 32'hFFFF0000, 32'h0, 5'd0, 5'd0);
      step();
    end
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);
`ifdef WB_RETIRE_CNT_EN
    expect_val(S_CNT, 32'd1, "cnt_wrap_17");
`else
    expect_val(S_CNT, 32'd0, "cnt_off_17");
`endif
    step();

    for (int k = 0; k < 20 && sb.size() != 0; k++) step();
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending checks expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
